// File: rtl/cop_gcd_lcm_ctrl.sv
// GCD/LCM coprocessor sequencer: subtractive Euclid GCD, then an exact
// repeated-subtraction divide and a shift-add multiply for LCM.
// The result is returned in a packed, registered status word.
module cop_gcd_lcm_ctrl #(
  parameter int unsigned W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [31:0] WDFinal,
  output logic [31:0] AnsData
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = $clog2(W);

  // The AnsData bit packing only works for 8-bit operands.
  if (W != 8) begin : g_bad_width
    $error("cop_gcd_lcm_ctrl: W must be 8");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_GCD,
    S_DIV,
    S_MUL,
    S_DONE
  } state_t;

  state_t         state;
  logic           start_q;
  logic           opq;
  logic [W-1:0]   a_orig;
  logic [W-1:0]   b_orig;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [W-1:0]   g;
  logic [W-1:0]   rem;
  logic [W-1:0]   q;
  logic [W-1:0]   mplier;
  logic [PW-1:0]  mcand;
  logic [PW-1:0]  prod;
  logic [CW-1:0]  cnt;

  logic           accept_c;
  logic [PW-1:0]  prod_nxt_c;
  logic           unused_cmd_bits;

  // The upper command bits carry no meaning for this engine.
  assign unused_cmd_bits = ^WDFinal[31:17];

  // New command: rising Start edge while idle or holding a result.
  assign accept_c = Start && !start_q && ((state == S_IDLE) || (state == S_DONE));

  // One shift-add step of the multiplier.
  assign prod_nxt_c = prod + (mplier[0] ? mcand : PW'(0));

  // Sequencer, datapath and registered status word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
      opq     <= 1'b0;
      a_orig  <= '0;
      b_orig  <= '0;
      a       <= '0;
      b       <= '0;
      g       <= '0;
      rem     <= '0;
      q       <= '0;
      mplier  <= '0;
      mcand   <= '0;
      prod    <= '0;
      cnt     <= '0;
      AnsData <= '0;
    end else begin
      start_q <= Start;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept_c) begin
            a_orig  <= WDFinal[W-1:0];
            b_orig  <= WDFinal[2*W-1:W];
            a       <= WDFinal[W-1:0];
            b       <= WDFinal[2*W-1:W];
            opq     <= WDFinal[16];
            AnsData <= 32'h0000_0200;
            state   <= S_GCD;
          end
        end
        S_GCD: begin
          if ((a == '0) || (b == '0)) begin
            // Zero operand: report error, both results zero.
            AnsData <= 32'h0000_0500;
            state   <= S_DONE;
          end else if (a > b) begin
            a <= a - b;
          end else if (b > a) begin
            b <= b - a;
          end else begin
            g <= a;
            if (opq) begin
              rem   <= a_orig;
              q     <= '0;
              state <= S_DIV;
            end else begin
              AnsData <= {16'h0000, 5'b00000, 1'b0, 1'b0, 1'b1, a};
              state   <= S_DONE;
            end
          end
        end
        S_DIV: begin
          // Exact divide a_orig / g; the last step is when rem equals g.
          rem <= rem - g;
          q   <= q + W'(1);
          if (rem == g) begin
            mplier <= q + W'(1);
            mcand  <= PW'(b_orig);
            prod   <= '0;
            cnt    <= '0;
            state  <= S_MUL;
          end
        end
        S_MUL: begin
          prod   <= prod_nxt_c;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) begin
            AnsData <= {prod_nxt_c, 5'b00000, 1'b0, 1'b0, 1'b1, g};
            state   <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cop_gcd_lcm_ctrl.sv
// Directed bench for cop_gcd_lcm_ctrl: stimulus pushes expected results and
// completion cycles; a monitor compares them on each rising done bit.
module tb_cop_gcd_lcm_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [31:0] WDFinal = 32'h0;
  logic [31:0] AnsData;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic prev_done = 1'b0;

  typedef struct {
    logic [31:0] ans;
    int          at;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  cop_gcd_lcm_ctrl #(.W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .Start   (Start),
    .WDFinal (WDFinal),
    .AnsData (AnsData)
  );

  always #5 clk = ~clk;

  // Edge counter: after edge k, the following negedge sees cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h want %08h", nm, act, exp);
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  // Monitor: every rising done bit must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_done = 1'b0;
    end else begin
      if (AnsData[8] && !prev_done) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: got %08h want none", AnsData);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_ans"}, AnsData, e.ans);
          check_int({e.name, "_cycle"}, cyc, e.at);
        end
      end
      prev_done = AnsData[8];
    end
  end

  // One-cycle Start pulse; checks the busy-only word at the accept edge.
  task automatic issue(input logic [31:0] w, input logic [31:0] exp_ans,
                       input int lat, input string nm, output int e0);
    @(negedge clk);
    Start   = 1'b1;
    WDFinal = w;
    e0      = cyc + 1;
    sb_q.push_back('{exp_ans, e0 + lat, nm});
    @(negedge clk);
    Start = 1'b0;
    check({nm, "_busy"}, AnsData, 32'h0000_0200);
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k = 0;
    while (!AnsData[8] && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!AnsData[8]) begin
      n_checks++;
      $display("FAIL %s_timeout: got done=0 want done=1 within %0d cycles", nm, budget);
    end
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    logic bad;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_hold", AnsData, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", AnsData, 32'h0);

    // GCD(12,8) with junk in ignored bits; result holds afterwards
    issue(32'hFFFE_080C, 32'h0000_0104, 3, "gcd_12_8", e0);
    wait_done("gcd_12_8", 20);
    repeat (5) @(negedge clk);
    check("gcd_12_8_hold", AnsData, 32'h0000_0104);

    // LCM(12,8): busy throughout E0..E0+13
    issue(32'h0001_080C, 32'h0018_0104, 14, "lcm_12_8", e0);
    bad = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (AnsData[9] !== 1'b1 || AnsData[8] !== 1'b0) bad = 1'b1;
    end
    check("lcm_12_8_busy_span", {31'h0, bad}, 32'h0);
    wait_done("lcm_12_8", 20);

    // Zero operands
    issue(32'h0001_0500, 32'h0000_0500, 1, "zero_a", e0);
    wait_done("zero_a", 5);
    issue(32'h0000_0007, 32'h0000_0500, 1, "zero_b", e0);
    wait_done("zero_b", 5);

    // Other LCM/GCD patterns
    issue(32'h0001_0609, 32'h0012_0103, 14, "lcm_9_6", e0);
    wait_done("lcm_9_6", 20);
    issue(32'h0001_0707, 32'h0007_0107, 10, "lcm_7_7", e0);
    wait_done("lcm_7_7", 20);
    issue(32'h0000_FEFF, 32'h0000_0101, 255, "gcd_255_254", e0);
    wait_done("gcd_255_254", 300);

    // Start held high for 20 cycles, command changed mid-hold
    @(negedge clk);
    Start   = 1'b1;
    WDFinal = 32'h0000_080C;
    e0      = cyc + 1;
    sb_q.push_back('{32'h0000_0104, e0 + 3, "held"});
    repeat (10) @(negedge clk);
    WDFinal = 32'h0001_080C;
    repeat (10) @(negedge clk);
    check("held_single_op", AnsData, 32'h0000_0104);
    Start = 1'b0;
    repeat (3) @(negedge clk);
    check("held_after_drop", AnsData, 32'h0000_0104);

    // Start re-pulsed while busy is ignored
    issue(32'h0001_080C, 32'h0018_0104, 14, "repulse", e0);
    @(negedge clk);
    Start   = 1'b1;
    WDFinal = 32'h0000_FEFF;
    @(negedge clk);
    Start = 1'b0;
    wait_done("repulse", 20);
    repeat (5) @(negedge clk);
    check("repulse_hold", AnsData, 32'h0018_0104);

    // Asynchronous reset mid-LCM, then a fresh worst-case LCM
    issue(32'h0001_FEFF, 32'hFD02_0101, 518, "lcm_aborted", e0);
    repeat (100) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("reset_async", AnsData, 32'h0);
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    issue(32'h0001_FEFF, 32'hFD02_0101, 518, "lcm_255_254", e0);
    wait_done("lcm_255_254", 600);

    repeat (3) @(negedge clk);
    check_int("scoreboard_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
